core_controller: RTL and testbench

//  Multi-cycle sequencer for the core datapath. Fetches each instruction over an imem
//  req/ack handshake and decodes opcode[30:25]. Drives the datapath mux selects
//  (next-PC, ALU src2, imm extend, write-back), the ALU op, the PC and register-file

---
 rtl/core_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_core_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/core_controller.sv
// core_controller: multi-cycle sequencer for the core datapath.
// Fetches each instruction over the imem req/ack handshake, decodes opcode ir[30:25],
// then drives the datapath selects, the ALU op, the PC and register-file write strobes,
// and the dmem req/ack handshake.
//
// Ports:
//   clk, rst (synchronous, active-low), enable (run; low parks in IDLE after WB)
//   instruction, imem_ack -> imem_req        instruction fetch handshake
//   dmem_ack              -> dmem_req/we     data access handshake (we: 1=store)
//   alu_zero                                 branch condition input
//   pc_we, reg_we                            write strobes, asserted in WB
//   select_pc/alu_src2/imm_extend/write_reg  datapath mux selects, valid EXEC..WB
//   alu_op                                   0 add, 1 sub, 2 and, 3 or, 4 xor
//   ir                                       latched instruction
//   illegal_instr                            one-cycle pulse in DECODE on unknown op
//
// Build option: CORE_CTRL_PERF_EN adds cycle_count (non-IDLE cycles) and
// retired_count (instructions passing WB) outputs.
//
// state  | meaning
// IDLE   | parked, waiting for enable
// FETCH  | imem_req high until imem_ack; ir loads on the ack edge
// DECODE | ir decoded, selects registered, illegal_instr pulse
// EXEC   | ALU evaluates; branch outcome resolved from alu_zero
// MEM    | dmem_req high until dmem_ack (loads/stores only)
// WB     | pc_we, optional reg_we; then FETCH or IDLE
module core_controller #(
    parameter int DataSize = 32,
    parameter int OpWidth  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [DataSize-1:0] instruction,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    input  logic                alu_zero,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                pc_we,
    output logic                reg_we,
    output logic [1:0]          select_pc,
    output logic [2:0]          select_alu_src2,
    output logic [1:0]          select_imm_extend,
    output logic [1:0]          select_write_reg,
    output logic [OpWidth-1:0]  alu_op,
    output logic [DataSize-1:0] ir,
    output logic                illegal_instr
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0]         cycle_count,
    output logic [31:0]         retired_count
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [5:0] OP_ALU1 = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b101000;
    localparam logic [5:0] OP_ORI  = 6'b101100;
    localparam logic [5:0] OP_MOVI = 6'b100010;
    localparam logic [5:0] OP_LWI  = 6'b000010;
    localparam logic [5:0] OP_SWI  = 6'b001010;
    localparam logic [5:0] OP_BR1  = 6'b100110;
    localparam logic [5:0] OP_J    = 6'b100100;

    localparam logic [OpWidth-1:0] ALU_ADD = OpWidth'(0);
    localparam logic [OpWidth-1:0] ALU_SUB = OpWidth'(1);
    localparam logic [OpWidth-1:0] ALU_AND = OpWidth'(2);
    localparam logic [OpWidth-1:0] ALU_OR  = OpWidth'(3);
    localparam logic [OpWidth-1:0] ALU_XOR = OpWidth'(4);

    state_t state, state_next;

    // Decoded fields, combinational from ir during DECODE
    logic               dec_legal, dec_mem, dec_store, dec_rwe, dec_br, dec_bne;
    logic [2:0]         dec_src2;
    logic [1:0]         dec_ext, dec_wr, dec_pc;
    logic [OpWidth-1:0] dec_aluop;

    // Registered at the DECODE edge and held through WB
    logic               mem_q, store_q, rwe_q, br_q, bne_q;
    logic [2:0]         src2_q;
    logic [1:0]         ext_q, wr_q, pc_q;
    logic [OpWidth-1:0] aluop_q;

    always_comb begin
        dec_legal = 1'b1;
        dec_mem   = 1'b0;
        dec_store = 1'b0;
        dec_rwe   = 1'b0;
        dec_br    = 1'b0;
        dec_bne   = 1'b0;
        dec_src2  = 3'b000;
        dec_ext   = 2'b00;
        dec_wr    = 2'b00;
        dec_pc    = 2'b00;
        dec_aluop = ALU_ADD;
        case (ir[30:25])
            OP_ALU1: begin
                dec_rwe  = 1'b1;
                dec_src2 = (ir[9:8] != 2'b00) ? 3'b011 : 3'b000;
                case (ir[4:0])
                    5'b00000: dec_aluop = ALU_ADD;
                    5'b00001: dec_aluop = ALU_SUB;
                    5'b00010: dec_aluop = ALU_AND;
                    5'b00100: dec_aluop = ALU_OR;
                    5'b00011: dec_aluop = ALU_XOR;
                    default:  dec_legal = 1'b0;
                endcase
            end
            OP_ADDI: begin dec_rwe = 1'b1; dec_ext = 2'b01; dec_src2 = 3'b001; end
            OP_ORI: begin
                dec_rwe = 1'b1; dec_ext = 2'b10; dec_src2 = 3'b001; dec_aluop = ALU_OR;
            end
            OP_MOVI: begin dec_rwe = 1'b1; dec_ext = 2'b11; dec_src2 = 3'b001; dec_wr = 2'b01; end
            OP_LWI:  begin dec_rwe = 1'b1; dec_mem = 1'b1; dec_src2 = 3'b010; dec_wr = 2'b10; end
            OP_SWI:  begin dec_mem = 1'b1; dec_store = 1'b1; dec_src2 = 3'b010; end
            OP_BR1: begin
                dec_br = 1'b1; dec_bne = ir[14]; dec_src2 = 3'b100; dec_aluop = ALU_SUB;
            end
            OP_J:    dec_pc = 2'b10;
            default: dec_legal = 1'b0;
        endcase
        // Unknown ops (including bad ALU_1 sub-ops) retire as a plain NOP
        if (!dec_legal) begin
            dec_rwe   = 1'b0;
            dec_src2  = 3'b000;
            dec_aluop = ALU_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ir      <= '0;
            mem_q   <= 1'b0;
            store_q <= 1'b0;
            rwe_q   <= 1'b0;
            br_q    <= 1'b0;
            bne_q   <= 1'b0;
            src2_q  <= '0;
            ext_q   <= '0;
            wr_q    <= '0;
            pc_q    <= '0;
            aluop_q <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH && imem_ack) ir <= instruction;
            if (state == DECODE) begin
                mem_q   <= dec_mem;
                store_q <= dec_store;
                rwe_q   <= dec_rwe;
                br_q    <= dec_br;
                bne_q   <= dec_bne;
                src2_q  <= dec_src2;
                ext_q   <= dec_ext;
                wr_q    <= dec_wr;
                pc_q    <= dec_pc;
                aluop_q <= dec_aluop;
            end
            if (state == EXEC && br_q)
                pc_q <= ((!bne_q && alu_zero) || (bne_q && !alu_zero)) ? 2'b01 : 2'b00;
        end
    end

    always_comb begin
        state_next        = state;
        imem_req          = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        pc_we             = 1'b0;
        reg_we            = 1'b0;
        illegal_instr     = 1'b0;
        select_pc         = 2'b00;
        select_alu_src2   = 3'b000;
        select_imm_extend = 2'b00;
        select_write_reg  = 2'b00;
        alu_op            = ALU_ADD;
        if (state == EXEC || state == MEM || state == WB) begin
            select_pc         = pc_q;
            select_alu_src2   = src2_q;
            select_imm_extend = ext_q;
            select_write_reg  = wr_q;
            alu_op            = aluop_q;
        end
        case (state)
            IDLE:   if (enable) state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = DECODE;
            end
            DECODE: begin
                illegal_instr = !dec_legal;
                state_next    = EXEC;
            end
            EXEC:   state_next = mem_q ? MEM : WB;
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = store_q;
                if (dmem_ack) state_next = WB;
            end
            WB: begin
                pc_we      = 1'b1;
                reg_we     = rwe_q;
                state_next = enable ? FETCH : IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs drop in the cycle reset is applied, so a pending handshake is withdrawn at once
        if (!rst) begin
            imem_req          = 1'b0;
            dmem_req          = 1'b0;
            dmem_we           = 1'b0;
            pc_we             = 1'b0;
            reg_we            = 1'b0;
            illegal_instr     = 1'b0;
            select_pc         = 2'b00;
            select_alu_src2   = 3'b000;
            select_imm_extend = 2'b00;
            select_write_reg  = 2'b00;
            alu_op            = ALU_ADD;
        end
    end

`ifdef CORE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state != IDLE) cycle_count <= cycle_count + 32'd1;
            if (state == WB) retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_controller.sv
module tb_core_controller;

    logic        clk = 1'b0;
    logic        rst, enable, imem_ack, dmem_ack, alu_zero;
    logic [31:0] instruction;
    logic        imem_req, dmem_req, dmem_we, pc_we, reg_we, illegal_instr;
    logic [1:0]  select_pc, select_imm_extend, select_write_reg;
    logic [2:0]  select_alu_src2, alu_op;
    logic [31:0] ir;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] cycle_count, retired_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    core_controller dut (
        .clk(clk), .rst(rst), .enable(enable), .instruction(instruction),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .reg_we(reg_we), .select_pc(select_pc),
        .select_alu_src2(select_alu_src2), .select_imm_extend(select_imm_extend),
        .select_write_reg(select_write_reg), .alu_op(alu_op), .ir(ir),
        .illegal_instr(illegal_instr)
`ifdef CORE_CTRL_PERF_EN
        , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [24:0] low);
        return {1'b0, op, low};
    endfunction

    initial begin
        rst = 1'b0; enable = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        alu_zero = 1'b0; instruction = '0;
        step(); step();
        rst = 1'b1;
        step();
        chk("reset_imem_req", 32'(imem_req), 0);
        chk("reset_pc_we",    32'(pc_we), 0);
        chk("reset_ir",       ir, 0);
        chk("reset_selects",  {select_pc, select_alu_src2, select_imm_extend, select_write_reg, alu_op}, 0);

        // ADDI, ack in the first FETCH cycle
        enable = 1'b1;
        step();
        chk("addi_fetch_req", 32'(imem_req), 1);
        instruction = mk(6'b101000, 25'h5); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        chk("addi_decode_req", 32'(imem_req), 0);
        chk("addi_ir", ir, mk(6'b101000, 25'h5));
        step();
        chk("addi_ext_src2", {select_imm_extend, select_alu_src2}, {2'b01, 3'b001});
        chk("addi_aluop_wr", {alu_op, select_write_reg}, 0);
        chk("addi_exec_pc_we", 32'(pc_we), 0);
        step();
        chk("addi_wb_strobes", {pc_we, reg_we}, 2'b11);

        // LWI with three memory wait cycles
        step();
        instruction = mk(6'b000010, 25'h0); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step();
        chk("lwi_exec_src2", 32'(select_alu_src2), 3'b010);
        step();
        chk("lwi_mem1", {dmem_req, dmem_we}, 2'b10);
        step();
        chk("lwi_mem2", {dmem_req, dmem_we}, 2'b10);
        step();
        chk("lwi_mem3", {dmem_req, dmem_we, pc_we}, 3'b100);
        dmem_ack = 1'b1;
        step(); dmem_ack = 1'b0;
        chk("lwi_wb", {dmem_req, pc_we, reg_we, select_write_reg}, {3'b011, 2'b10});

        // BEQ taken
        step();
        instruction = mk(6'b100110, 25'h0); imem_ack = 1'b1; alu_zero = 1'b1;
        step(); imem_ack = 1'b0;
        step();
        chk("beq_src2_op", {select_alu_src2, alu_op}, {3'b100, 3'd1});
        step();
        chk("beq_wb", {select_pc, pc_we, reg_we}, {2'b01, 2'b10});

        // BNE not taken
        step();
        instruction = mk(6'b100110, 25'h4000); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step(); step();
        chk("bne_wb", {select_pc, pc_we, reg_we}, {2'b00, 2'b10});

        // Illegal opcode
        step();
        instruction = mk(6'b111111, 25'h0); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        chk("illegal_pulse", 32'(illegal_instr), 1);
        step();
        chk("illegal_gone", 32'(illegal_instr), 0);
        step();
        chk("illegal_wb", {select_pc, pc_we, reg_we}, {2'b00, 2'b10});

        // Jump
        step();
        instruction = mk(6'b100100, 25'h0); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        chk("j_legal", 32'(illegal_instr), 0);
        step(); step();
        chk("j_wb", {select_pc, pc_we, reg_we}, {2'b10, 2'b10});

        // ALU_1 xor with shifted rb
        step();
        instruction = mk(6'b100000, 25'h103); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step();
        chk("xor_src2_op", {select_alu_src2, alu_op, select_write_reg}, {3'b011, 3'd4, 2'b00});
        step();
        chk("xor_wb", {pc_we, reg_we}, 2'b11);

        // SWI with enable dropped during MEM
        step();
        instruction = mk(6'b001010, 25'h0); imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step(); step();
        chk("swi_mem", {dmem_req, dmem_we}, 2'b11);
        enable = 1'b0;
        step();
        chk("swi_mem_hold", {dmem_req, dmem_we}, 2'b11);
        dmem_ack = 1'b1;
        step(); dmem_ack = 1'b0;
        chk("swi_wb", {pc_we, reg_we}, 2'b10);
        step();
        chk("idle_no_req1", {imem_req, pc_we}, 0);
        step(); step();
        chk("idle_no_req2", 32'(imem_req), 0);
        enable = 1'b1;
        step();
        chk("resume_fetch", 32'(imem_req), 1);

        // Reset mid-FETCH, then a late ack
        step();
        rst = 1'b0; enable = 1'b0;
        #1;
        chk("rst_req_drop", 32'(imem_req), 0);
        step();
        rst = 1'b1; imem_ack = 1'b1; instruction = 32'hDEAD_BEEF;
        step();
        chk("late_ack_req", 32'(imem_req), 0);
        chk("late_ack_ir", ir, 0);
        step();
        chk("late_ack_ir2", ir, 0);
        chk("late_ack_outs", {dmem_req, pc_we, reg_we, select_pc, select_alu_src2}, 0);
`ifdef CORE_CTRL_PERF_EN
        chk("perf_cycle_rst", cycle_count, 0);
        chk("perf_retired_rst", retired_count, 0);
`endif
        imem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
